// File: rtl/traffic_light_ctrl.sv
// ----------------------------------------------------------------------------
// traffic_light_ctrl
//
// Main/side-street intersection controller with a pedestrian walk phase,
// sensor-driven green extension and a night flashing mode. All phase timing
// is counted in single-cycle `tick` enables from an upstream prescaler.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   synchronous, active-high; dominates all other inputs
//   tick         in   one-cycle timing enable for the in-phase counter
//   walk         in   pedestrian button (1-cycle pulse is enough)
//   sensor       in   side-street vehicle present (level)
//   night_mode   in   flashing-mode request (level)
//   main_light   out  {r,y,g} for the main street
//   side_light   out  {r,y,g} for the side street
//   walk_on      out  pedestrian walk lamp
//   walk_pending out  a walk request is latched and not yet served
//   state_out    out  current state encoding
// ----------------------------------------------------------------------------
module traffic_light_ctrl #(
    parameter int CNT_W  = 4,
    parameter int T_BASE = 6,
    parameter int T_EXT  = 3,
    parameter int T_YEL  = 2,
    parameter int T_WALK = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       walk,
    input  logic       sensor,
    input  logic       night_mode,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk_on,
    output logic       walk_pending,
    output logic [2:0] state_out
);

    // Every duration must fit the counter so phase-end compares never wrap.
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    generate
        if (CNT_W < 1 ||
            T_BASE < 1 || T_BASE > CNT_MAX ||
            T_EXT  < 1 || T_EXT  > CNT_MAX ||
            T_YEL  < 1 || T_YEL  > CNT_MAX ||
            T_WALK < 1 || T_WALK > CNT_MAX) begin : g_bad_params
            $error("traffic_light_ctrl: phase durations must be in 1..2^CNT_W-1");
        end
    endgenerate

    // Counter value on the last tick of each phase.
    localparam logic [CNT_W-1:0] BASE_LAST = CNT_W'(T_BASE - 1);
    localparam logic [CNT_W-1:0] EXT_LAST  = CNT_W'(T_EXT - 1);
    localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(T_YEL - 1);
    localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(T_WALK - 1);

    typedef enum logic [2:0] {
        MAIN_G   = 3'd0,
        MAIN_EXT = 3'd1,
        MAIN_Y   = 3'd2,
        WALK     = 3'd3,
        SIDE_G   = 3'd4,
        SIDE_EXT = 3'd5,
        SIDE_Y   = 3'd6,
        FLASH    = 3'd7
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] phase_last;
    logic             phase_end;
    logic             flash;
    logic             walk_q;

    // Last counter value of the current phase (FLASH has no duration).
    always_comb begin
        phase_last = '0;
        case (state)
            MAIN_G, SIDE_G:     phase_last = BASE_LAST;
            MAIN_EXT, SIDE_EXT: phase_last = EXT_LAST;
            MAIN_Y, SIDE_Y:     phase_last = YEL_LAST;
            WALK:               phase_last = WALK_LAST;
            default:            phase_last = '0;
        endcase
    end

    assign phase_end = tick && (state != FLASH) && (cnt == phase_last);

    // Next state; only a phase-ending tick (or any tick in FLASH) can move it.
    always_comb begin
        state_nx = state;
        if (state == FLASH) begin
            if (tick && !night_mode)
                state_nx = MAIN_G;
        end else if (phase_end) begin
            case (state)
                MAIN_G:   state_nx = sensor ? MAIN_EXT : MAIN_Y;
                MAIN_EXT: state_nx = MAIN_Y;
                MAIN_Y:   state_nx = walk_q ? WALK : SIDE_G;
                WALK:     state_nx = SIDE_G;
                SIDE_G:   state_nx = sensor ? SIDE_EXT : SIDE_Y;
                SIDE_EXT: state_nx = SIDE_Y;
                SIDE_Y:   state_nx = night_mode ? FLASH : MAIN_G;
                default:  state_nx = MAIN_G;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= MAIN_G;
            cnt    <= '0;
            flash  <= 1'b0;
            walk_q <= 1'b0;
        end else begin
            state <= state_nx;

            // Every phase ends in a different state, so the counter is
            // always cleared before it could pass phase_last.
            if (state_nx != state)
                cnt <= '0;
            else if (tick && state != FLASH)
                cnt <= cnt + CNT_W'(1);

            if (state == FLASH && tick)
                flash <= night_mode ? ~flash : 1'b0;
            else if (state != FLASH)
                flash <= 1'b0;

            // WALK entry consumes the request, including a press in the
            // entry cycle; presses during WALK are dropped.
            if (state_nx == WALK && state != WALK)
                walk_q <= 1'b0;
            else if (walk && state != WALK)
                walk_q <= 1'b1;
        end
    end

    // Lamp decode from the registered state and flash bit.
    always_comb begin
        main_light = 3'b001;
        side_light = 3'b100;
        walk_on    = 1'b0;
        case (state)
            MAIN_G, MAIN_EXT: begin
                main_light = 3'b001;
                side_light = 3'b100;
            end
            MAIN_Y: begin
                main_light = 3'b010;
                side_light = 3'b100;
            end
            WALK: begin
                main_light = 3'b100;
                side_light = 3'b100;
                walk_on    = 1'b1;
            end
            SIDE_G, SIDE_EXT: begin
                main_light = 3'b100;
                side_light = 3'b001;
            end
            SIDE_Y: begin
                main_light = 3'b100;
                side_light = 3'b010;
            end
            FLASH: begin
                main_light = {1'b0, flash, 1'b0};
                side_light = {flash, 2'b00};
            end
            default: begin
                main_light = 3'b001;
                side_light = 3'b100;
            end
        endcase
    end

    assign walk_pending = walk_q;
    assign state_out    = state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// ----------------------------------------------------------------------------
// tb_traffic_light_ctrl
//
// Scoreboard bench: the driver applies inputs on the falling edge, steps a
// phase/remaining-ticks reference model and queues the expected outputs for
// the following rising edge; the monitor pops and compares 1 time unit after
// each rising edge.
// ----------------------------------------------------------------------------
module tb_traffic_light_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       walk = 1'b0;
    logic       sensor = 1'b0;
    logic       night_mode = 1'b0;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk_on;
    logic       walk_pending;
    logic [2:0] state_out;

    traffic_light_ctrl #(
        .CNT_W (4),
        .T_BASE(6),
        .T_EXT (3),
        .T_YEL (2),
        .T_WALK(3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .tick        (tick),
        .walk        (walk),
        .sensor      (sensor),
        .night_mode  (night_mode),
        .main_light  (main_light),
        .side_light  (side_light),
        .walk_on     (walk_on),
        .walk_pending(walk_pending),
        .state_out   (state_out)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0] m;
        logic [2:0] s;
        logic       w;
        logic       p;
        logic [2:0] st;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_no = 0;

    // Reference model: phase number 0..7, ticks left in phase, flash, pending.
    int m_phase = 0;
    int m_left  = 6;
    int m_flash = 0;
    int m_pend  = 0;
    int dur[7] = '{6, 3, 2, 3, 6, 3, 2};
    logic [2:0] main_tab[7] = '{3'b001, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] side_tab[7] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b001, 3'b010};

    function automatic exp_t model_out();
        exp_t e;
        e.st = 3'(m_phase);
        e.p  = (m_pend != 0);
        e.w  = (m_phase == 3);
        if (m_phase == 7) begin
            e.m = {1'b0, (m_flash != 0), 1'b0};
            e.s = {(m_flash != 0), 2'b00};
        end else begin
            e.m = main_tab[m_phase];
            e.s = side_tab[m_phase];
        end
        return e;
    endfunction

    task automatic model_step(input logic r, input logic t, input logic w,
                              input logic s, input logic n);
        int nxt;
        int left;
        nxt  = m_phase;
        left = m_left;
        if (r) begin
            m_phase = 0;
            m_left  = dur[0];
            m_flash = 0;
            m_pend  = 0;
            return;
        end
        if (t) begin
            if (m_phase == 7) begin
                if (!n) begin
                    nxt     = 0;
                    m_flash = 0;
                end else begin
                    m_flash = 1 - m_flash;
                end
            end else begin
                left = m_left - 1;
                if (left == 0) begin
                    case (m_phase)
                        0: nxt = s ? 1 : 2;
                        1: nxt = 2;
                        2: nxt = (m_pend != 0) ? 3 : 4;
                        3: nxt = 4;
                        4: nxt = s ? 5 : 6;
                        5: nxt = 6;
                        default: nxt = n ? 7 : 0;
                    endcase
                end
            end
        end
        if (nxt == 3 && m_phase != 3)
            m_pend = 0;
        else if (w && m_phase != 3)
            m_pend = 1;
        if (nxt != m_phase)
            m_left = (nxt == 7) ? 0 : dur[nxt];
        else
            m_left = left;
        m_phase = nxt;
    endtask

    task automatic cyc(input logic r, input logic t, input logic w,
                       input logic s, input logic n);
        @(negedge clock);
        reset      = r;
        tick       = t;
        walk       = w;
        sensor     = s;
        night_mode = n;
        model_step(r, t, w, s, n);
        q.push_back(model_out());
    endtask

    // n ticks, one every 4 clocks.
    task automatic ticks(input int n, input logic s, input logic nt);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b1, 1'b0, s, nt);
            repeat (3) cyc(1'b0, 1'b0, 1'b0, s, nt);
        end
    endtask

    task automatic wait_phase(input int p, input logic s, input logic nt);
        int k;
        k = 0;
        while (m_phase != p && k < 400) begin
            cyc(1'b0, (k % 4) == 0, 1'b0, s, nt);
            k++;
        end
        if (m_phase != p) begin
            checks++;
            errors++;
            $display("FAIL wait_phase timeout: phase %0d required %0d", m_phase, p);
        end
    endtask

    // Monitor
    initial begin
        exp_t e;
        exp_t g;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                g = '{m: main_light, s: side_light, w: walk_on, p: walk_pending, st: state_out};
                cyc_no++;
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL outputs@%0d got main=%b side=%b walk_on=%b pend=%b state=%0d required main=%b side=%b walk_on=%b pend=%b state=%0d",
                             cyc_no, g.m, g.s, g.w, g.p, g.st, e.m, e.s, e.w, e.p, e.st);
                end
            end
        end
    end

    // Driver
    initial begin
        logic s_r;
        logic n_r;
        logic t;
        logic w;
        int   k;

        // Reset, plain cycle with no sensor/walk/night.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(17, 1'b0, 1'b0);

        // Sensor held: extended cycle, then sensor dropped mid MAIN_EXT.
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        ticks(22, 1'b1, 1'b0);
        ticks(7, 1'b1, 1'b0);
        ticks(16, 1'b0, 1'b0);

        // Walk pulse two ticks into MAIN_G.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ticks(2, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        ticks(22, 1'b0, 1'b0);

        // Presses in the WALK-entry cycle and during WALK are consumed/ignored.
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 200; i++) begin
            t = (i % 4) == 0;
            w = (m_phase == 3) || (t && m_phase == 2 && m_left == 1 && m_pend != 0);
            cyc(1'b0, t, w, 1'b0, 1'b0);
        end

        // Night mode raised in SIDE_G, walk press in FLASH, then released.
        wait_phase(4, 1'b0, 1'b0);
        ticks(12, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        ticks(5, 1'b0, 1'b1);
        ticks(20, 1'b0, 1'b0);

        // Reset mid SIDE_EXT with a pending walk and a tick in the reset cycle.
        wait_phase(4, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_phase(5, 1'b1, 1'b0);
        ticks(1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        ticks(8, 1'b0, 1'b0);

        // Randomised traffic.
        s_r = 1'b0;
        n_r = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(29, 0) == 0) s_r = ~s_r;
            if ($urandom_range(299, 0) == 0) n_r = ~n_r;
            cyc($urandom_range(799, 0) == 0, $urandom_range(2, 0) == 0,
                $urandom_range(24, 0) == 0, s_r, n_r);
        end

        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        k = 0;
        while (q.size() > 0 && k < 20) begin
            @(posedge clock);
            k++;
        end
        #2;
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
Parametrised main/side-street intersection controller with a pedestrian walk phase, sensor-driven green extension and a night flashing mode. It runs on a single clock. All timing is counted in `tick` pulses (one-cycle enables from an upstream prescaler), so no second clock domain is needed. Phase durations are parameters, and state is exported for display and debug logic.

Parameters:
- CNT_W, 4: width of the in-phase tick counter; every duration must be in 1..2^CNT_W-1.
- T_BASE, 6: base green length in ticks, for both main and side.
- T_EXT, 3: green extension in ticks, taken when `sensor`=1 at the end of a base green.
- T_YEL, 2: yellow length in ticks.
- T_WALK, 3: walk phase length in ticks; all vehicle lights are red.

Ports:
- clock, input, 1: system clock; all logic is on the rising edge.
- reset, input, 1: synchronous, active-high; dominates every other input.
- tick, input, 1: one-cycle timing enable; the counter only advances on cycles where tick=1.
- walk, input, 1: pedestrian button, asynchronous to tick; a 1-cycle pulse is sufficient.
- sensor, input, 1: side-street vehicle present; level-sampled.
- night_mode, input, 1: request for flashing mode; level-sampled.
- main_light, output, 3: {r,y,g} for the main street.
- side_light, output, 3: {r,y,g} for the side street.
- walk_on, output, 1: pedestrian "walk" lamp.
- walk_pending, output, 1: a walk request is latched and not yet served.
- state_out, output, 3: current state encoding.

Behaviour:
- States and encodings, with light patterns as main/side {r,y,g}:
  - MAIN_G=0: 001/100
  - MAIN_EXT=1: 001/100
  - MAIN_Y=2: 010/100
  - WALK=3: 100/100, walk_on=1
  - SIDE_G=4: 100/001
  - SIDE_EXT=5: 100/001
  - SIDE_Y=6: 100/010
  - FLASH=7: main={0,flash,0}, side={flash,0,0}
- Outputs are a combinational decode of the registered state and flash bit. There is no latency beyond the state register.
- Tick counter:
  - Cleared to 0 on every state change.
  - Otherwise increments on tick.
  - A phase of length N ends on the tick where counter==N-1, so every phase lasts exactly N ticks.
  - Cycles without tick change nothing.
- Transitions, evaluated only at a phase-ending tick:
  - MAIN_G -> MAIN_EXT if sensor=1, else -> MAIN_Y.
  - MAIN_EXT -> MAIN_Y.
  - MAIN_Y -> WALK if walk_pending=1, else -> SIDE_G.
  - WALK -> SIDE_G.
  - SIDE_G -> SIDE_EXT if sensor=1, else -> SIDE_Y.
  - SIDE_EXT -> SIDE_Y.
  - SIDE_Y -> FLASH if night_mode=1, else -> MAIN_G.
- FLASH:
  - The flash bit toggles on each tick.
  - The state exits to MAIN_G on the first tick with night_mode=0; flash clears on exit.
  - No duration parameter applies.
- night_mode asserted in any other state has no effect until the SIDE_Y exit.
- sensor is sampled only at the MAIN_G and SIDE_G ending ticks. Changes during an extension do not shorten or lengthen it.
- walk_pending:
  - Set on the clock after any cycle with walk=1.
  - Cleared on the clock the state enters WALK.
  - A press in the same cycle as WALK entry is consumed by that WALK (pending ends at 0).
  - Presses while in WALK are ignored.
  - Presses while in FLASH are retained and served on the first MAIN_Y exit after FLASH ends.
- Reset:
  - Next clock: state=MAIN_G, counter=0, flash=0, walk_pending=0.
  - Outputs: main_light=001, side_light=100, walk_on=0, state_out=0.
  - Applies mid-phase as well, and a tick in the reset cycle is ignored.
- Counter never wraps: all phase-ending compares are equality on values below 2^CNT_W. Out-of-range parameters are an elaboration error, enforced by a generate-time check.
- Illegal state encodings cannot occur (3 bits, 8 states). The decode default still forces MAIN_G-equivalent outputs.

Test Plan:
- Reset, sensor=0, walk=0, night_mode=0, tick every 4 clocks -> MAIN_G 6 ticks, MAIN_Y 2, SIDE_G 6, SIDE_Y 2, back to MAIN_G after 16 ticks; walk_on never 1.
- sensor held 1 -> MAIN_G 6 + MAIN_EXT 3 + MAIN_Y 2 + SIDE_G 6 + SIDE_EXT 3 + SIDE_Y 2 = 22-tick cycle; dropping sensor mid-MAIN_EXT still gives the full 3 ticks.
- 1-clock walk pulse at tick 2 of MAIN_G -> walk_pending=1 on the next clock. After MAIN_Y: WALK for 3 ticks, lights 100/100, walk_on=1, walk_pending=0 from the WALK-entry clock. Then SIDE_G.
- walk pulses during WALK and in the WALK-entry cycle -> the next full cycle has no WALK and walk_pending stays 0.
- night_mode=1 raised during SIDE_G -> FLASH entered after SIDE_Y; main_light alternates 010/000 and side_light 100/000 every tick. A walk press in FLASH gives walk_pending=1. night_mode=0 -> MAIN_G on the next tick with the counter at 0, then WALK after the first MAIN_Y.
- reset asserted for 1 clock mid-SIDE_EXT with walk_pending=1 and tick=1 in the same cycle -> next clock state_out=0, lights 001/100, walk_pending=0, and MAIN_G then lasts a full 6 ticks.
